// File: rtl/router_pkg.sv
// Shared state encodings, default parameters and output decode for the
// packet router FSM.
package router_pkg;

    localparam int NUM_CH_DEF       = 3;
    localparam int ADDR_W_DEF       = 2;
    localparam int WAIT_TIMEOUT_DEF = 255;

    typedef logic [3:0] state_t;

    localparam state_t DECODE_ADDRESS     = 4'd0;
    localparam state_t LOAD_FIRST_DATA    = 4'd1;
    localparam state_t LOAD_DATA          = 4'd2;
    localparam state_t FIFO_FULL_STATE    = 4'd3;
    localparam state_t LOAD_AFTER_FULL    = 4'd4;
    localparam state_t LOAD_PARITY        = 4'd5;
    localparam state_t CHECK_PARITY_ERROR = 4'd6;
    localparam state_t WAIT_TILL_EMPTY    = 4'd7;
    localparam state_t DROP_PACKET        = 4'd8;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic full_state;
        logic laf_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
    } flags_t;

    // Moore decode; unused encodings decode to all-zero.
    function automatic flags_t decode_state(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            DECODE_ADDRESS:     f.detect_add = 1'b1;
            LOAD_FIRST_DATA:    begin f.lfd_state = 1'b1; f.busy = 1'b1; end
            LOAD_DATA:          begin f.ld_state = 1'b1; f.write_enb_reg = 1'b1; end
            FIFO_FULL_STATE:    begin f.full_state = 1'b1; f.busy = 1'b1; end
            LOAD_AFTER_FULL:    begin f.laf_state = 1'b1; f.write_enb_reg = 1'b1; f.busy = 1'b1; end
            LOAD_PARITY:        begin f.write_enb_reg = 1'b1; f.busy = 1'b1; end
            CHECK_PARITY_ERROR: begin f.rst_int_reg = 1'b1; f.busy = 1'b1; end
            WAIT_TILL_EMPTY:    f.busy = 1'b1;
            default:            f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Saturating cycle counter for the wait-till-empty state; expired flags the
// last permitted waiting cycle.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = (WAIT_TIMEOUT > 0) ? CNT_W'(WAIT_TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_r;

    // Count waiting cycles, holding at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (WAIT_TIMEOUT > 0) && enable && (count_r == LAST);

endmodule

// File: rtl/router_fsm_nch.sv
// Packet router control FSM for NUM_CH output channels, with invalid-address
// drop and bounded wait for a busy destination FIFO.
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int ADDR_W       = $clog2(NUM_CH),
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              fifo_full,
    input  logic              low_pkt_valid,
    input  logic              parity_done,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_err,
    output logic              drop_pkt
);

    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    state_t state_r;
    state_t next_state_s;
    flags_t flags_r;
    logic   addr_valid_s;
    logic   load_addr_s;
    logic   addr_err_s;
    logic   drop_pkt_s;
    logic   timer_clear_s;
    logic   timer_enable_s;
    logic   timer_expired_s;

    assign addr_valid_s   = ({1'b0, data_in} < NUM_CH_W);
    assign timer_enable_s = (state_r == WAIT_TILL_EMPTY);
    assign timer_clear_s  = (next_state_s == WAIT_TILL_EMPTY) && (state_r != WAIT_TILL_EMPTY);

    router_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (timer_expired_s)
    );

    // Next-state logic; a soft reset of the active channel overrides everything.
    always_comb begin
        next_state_s = state_r;
        load_addr_s  = 1'b0;
        addr_err_s   = 1'b0;
        drop_pkt_s   = 1'b0;
        if ((state_r != DECODE_ADDRESS) && soft_reset[addr_out]) begin
            next_state_s = DECODE_ADDRESS;
        end else begin
            case (state_r)
                DECODE_ADDRESS: begin
                    if (pkt_valid) begin
                        if (addr_valid_s) begin
                            load_addr_s = 1'b1;
                            if (fifo_empty[data_in]) begin
                                next_state_s = LOAD_FIRST_DATA;
                            end else begin
                                next_state_s = WAIT_TILL_EMPTY;
                            end
                        end else begin
                            next_state_s = DROP_PACKET;
                            addr_err_s   = 1'b1;
                        end
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                LOAD_FIRST_DATA: next_state_s = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else begin
                        next_state_s = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        next_state_s = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                LOAD_PARITY: next_state_s = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (fifo_empty[addr_out]) begin
                        next_state_s = LOAD_FIRST_DATA;
                    end else if (timer_expired_s) begin
                        next_state_s = DROP_PACKET;
                        drop_pkt_s   = 1'b1;
                    end else begin
                        next_state_s = WAIT_TILL_EMPTY;
                    end
                end
                DROP_PACKET: begin
                    if (pkt_valid) begin
                        next_state_s = DROP_PACKET;
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                default: next_state_s = DECODE_ADDRESS;
            endcase
        end
    end

    // State, address latch and registered output decodes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= DECODE_ADDRESS;
            flags_r  <= decode_state(DECODE_ADDRESS);
            addr_out <= '0;
            addr_err <= 1'b0;
            drop_pkt <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            flags_r  <= decode_state(next_state_s);
            addr_out <= load_addr_s ? data_in : addr_out;
            addr_err <= addr_err_s;
            drop_pkt <= drop_pkt_s;
        end
    end

    assign detect_add    = flags_r.detect_add;
    assign lfd_state     = flags_r.lfd_state;
    assign ld_state      = flags_r.ld_state;
    assign full_state    = flags_r.full_state;
    assign laf_state     = flags_r.laf_state;
    assign rst_int_reg   = flags_r.rst_int_reg;
    assign write_enb_reg = flags_r.write_enb_reg;
    assign busy          = flags_r.busy;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed and randomized bench for router_fsm_nch against a behavioural
// model of the packet flow (3 channels, wait timeout of 8 cycles).
module tb_router_fsm_nch;

    localparam int NCH = 3;
    localparam int TMO = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       fifo_full;
    logic       low_pkt_valid;
    logic       parity_done;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [1:0] addr_out;
    logic       addr_err, drop_pkt;

    int checks   = 0;
    int failures = 0;

    typedef enum {M_DEC, M_LFD, M_LD, M_FULL, M_LAF, M_LP, M_CPE, M_WAIT, M_DROP} m_state_e;
    m_state_e   ms = M_DEC;
    logic [1:0] m_addr = 2'd0;
    logic       m_err = 1'b0;
    logic       m_drop = 1'b0;
    int         m_waited = 0;

    router_fsm_nch #(.NUM_CH(NCH), .ADDR_W(2), .WAIT_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset), .fifo_full(fifo_full),
        .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .addr_out(addr_out),
        .addr_err(addr_err), .drop_pkt(drop_pkt)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] obs_flags();
        return {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg, write_enb_reg, busy};
    endfunction

    // {detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}
    function automatic logic [7:0] exp_flags(input m_state_e s);
        case (s)
            M_DEC:   return 8'b1000_0000;
            M_LFD:   return 8'b0100_0001;
            M_LD:    return 8'b0010_0010;
            M_FULL:  return 8'b0001_0001;
            M_LAF:   return 8'b0000_1011;
            M_LP:    return 8'b0000_0011;
            M_CPE:   return 8'b0000_0101;
            M_WAIT:  return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare();
        chk("flags", 32'(obs_flags()), 32'(exp_flags(ms)));
        chk("addr_out", 32'(addr_out), 32'(m_addr));
        chk("pulses", 32'({addr_err, drop_pkt}), 32'({m_err, m_drop}));
    endtask

    // Packet-level rules applied to the inputs present at the clock edge.
    task automatic model_edge();
        m_state_e nx;
        nx = ms;
        m_err = 1'b0;
        m_drop = 1'b0;
        if (ms != M_DEC && soft_reset[m_addr]) begin
            nx = M_DEC;
        end else begin
            case (ms)
                M_DEC: if (pkt_valid) begin
                    if (int'(data_in) < NCH) begin
                        m_addr = data_in;
                        if (fifo_empty[data_in]) nx = M_LFD;
                        else begin nx = M_WAIT; m_waited = 0; end
                    end else begin
                        nx = M_DROP; m_err = 1'b1;
                    end
                end
                M_LFD:  nx = M_LD;
                M_LD:   nx = fifo_full ? M_FULL : (!pkt_valid ? M_LP : M_LD);
                M_FULL: nx = fifo_full ? M_FULL : M_LAF;
                M_LAF:  nx = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
                M_LP:   nx = M_CPE;
                M_CPE:  nx = fifo_full ? M_FULL : M_DEC;
                M_WAIT: begin
                    m_waited++;
                    if (fifo_empty[m_addr]) nx = M_LFD;
                    else if (TMO > 0 && m_waited == TMO) begin nx = M_DROP; m_drop = 1'b1; end
                end
                M_DROP: nx = pkt_valid ? M_DROP : M_DEC;
                default: nx = M_DEC;
            endcase
        end
        ms = nx;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic pv, input logic [1:0] din, input logic [2:0] fe,
                         input logic ff, input logic lpv, input logic pd, input logic [2:0] sr);
        pkt_valid = pv; data_in = din; fifo_empty = fe; fifo_full = ff;
        low_pkt_valid = lpv; parity_done = pd; soft_reset = sr;
        step();
    endtask

    task automatic model_reset();
        ms = M_DEC; m_addr = 2'd0; m_err = 1'b0; m_drop = 1'b0; m_waited = 0;
    endtask

    // Reset pulse between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        compare();
        #1 reset = 1'b0;
    endtask

    int n_count;

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_empty = 3'b000;
        soft_reset = 3'b000; fifo_full = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b0;
        #3 model_reset();
        compare();
        #4 reset = 1'b0;

        // Normal packet to channel 2.
        drive(1'b1, 2'd2, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("hdr_addr_out", 32'(addr_out), 32'd2);
        repeat (3) drive(1'b1, 2'd2, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("ld_before_parity", 32'(ld_state), 32'd1);
        repeat (3) drive(1'b0, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("back_to_decode", 32'(detect_add), 32'd1);

        // Invalid address: drop until pkt_valid falls.
        drive(1'b1, 2'd3, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("addr_err_pulse", 32'(addr_err), 32'd1);
        drive(1'b1, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("addr_err_single", 32'(addr_err), 32'd0);
        chk("drop_no_write", 32'(write_enb_reg), 32'd0);
        drive(1'b0, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);

        // Wait timeout on channel 1.
        drive(1'b1, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000);
        n_count = 0;
        for (int i = 0; i < 20; i++) begin
            if (obs_flags() != 8'b0000_0001) break;
            n_count++;
            drive(1'b1, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000);
        end
        chk("wait_cycles", 32'(n_count), 32'd8);
        chk("drop_pkt_pulse", 32'(drop_pkt), 32'd1);
        drive(1'b1, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("drop_pkt_single", 32'(drop_pkt), 32'd0);
        drive(1'b0, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000);

        // FIFO empties on the last permitted wait cycle: load wins.
        drive(1'b1, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000);
        repeat (7) drive(1'b1, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("late_empty_lfd", 32'(lfd_state), 32'd1);
        chk("late_empty_no_drop", 32'(drop_pkt), 32'd0);
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        repeat (3) drive(1'b0, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);

        // FIFO full for three cycles during load.
        drive(1'b1, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        n_count = 0;
        repeat (3) begin
            drive(1'b1, 2'd0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000);
            if (full_state) n_count++;
        end
        chk("full_cycles", 32'(n_count), 32'd3);
        drive(1'b0, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("laf_after_full", 32'(laf_state), 32'd1);
        drive(1'b0, 2'd0, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000);
        repeat (2) drive(1'b0, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);

        // Soft reset only acts on the active channel; async reset mid-packet.
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b100);
        chk("soft_reset_other", 32'(ld_state), 32'd1);
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b010);
        chk("soft_reset_own", 32'(detect_add), 32'd1);
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 2'd1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        async_reset();
        chk("async_reset_detect", 32'(detect_add), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 3'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000);
            if ($urandom_range(0, 249) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
